// File: rtl/regbus_arbiter_pkg.sv
// Shared types and constants for the PWM register-bus arbiter: FSM state and
// owner encodings, plus the register-bus field widths.
package regbus_arbiter_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_REQ0 = 2'b01;
  localparam logic [1:0] OWNER_REQ1 = 2'b10;

  // State codes share the owner encoding so owner can be read straight off the state.
  typedef enum logic [1:0] {
    ST_IDLE = OWNER_NONE,
    ST_GNT0 = OWNER_REQ0,
    ST_GNT1 = OWNER_REQ1
  } state_e;

  function automatic logic [1:0] owner_of(input state_e st);
    case (st)
      ST_GNT0: owner_of = OWNER_REQ0;
      ST_GNT1: owner_of = OWNER_REQ1;
      default: owner_of = OWNER_NONE;
    endcase
  endfunction

endpackage

// File: rtl/regbus_arbiter.sv
// Two-requester round-robin arbiter with lock and lock timeout in front of the
// PWM register block's single read/write port.
module regbus_arbiter
  import regbus_arbiter_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_i,
  input  logic              req1_i,
  input  logic              lock0_i,
  input  logic              lock1_i,
  input  logic              we0_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack0_o,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              read_o,
  output logic              write_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_write_o,
  input  logic [DATA_W-1:0] data_read_i,
  output logic [1:0]        owner_o,
  output logic              lock_timeout_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             locked_q, locked_d;
  logic             rr_q, rr_d;        // 0: requester 0 wins a tie, 1: requester 1
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Owner-side view of the two request channels
  logic              own_req;
  logic              own_lock;
  logic              own_we;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;

  always_comb begin
    if (state_q == ST_GNT1) begin
      own_req   = req1_i;
      own_lock  = lock1_i;
      own_we    = we1_i;
      own_addr  = addr1_i;
      own_wdata = wdata1_i;
    end else begin
      own_req   = req0_i;
      own_lock  = lock0_i;
      own_we    = we0_i;
      own_addr  = addr0_i;
      own_wdata = wdata0_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      locked_q <= 1'b0;
      rr_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    locked_d       = locked_q;
    rr_d           = rr_q;
    cnt_d          = cnt_q;
    ack0_o         = 1'b0;
    ack1_o         = 1'b0;
    rdata0_o       = '0;
    rdata1_o       = '0;
    read_o         = 1'b0;
    write_o        = 1'b0;
    addr_o         = '0;
    data_write_o   = '0;
    lock_timeout_o = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0_i && (!req1_i || !rr_q)) begin
          state_d = ST_GNT0;
          rr_d    = 1'b1;
        end else if (req1_i) begin
          state_d = ST_GNT1;
          rr_d    = 1'b0;
        end
      end

      ST_GNT0, ST_GNT1: begin
        read_o  = own_req & ~own_we;
        write_o = own_req & own_we;
        if (own_req) begin
          addr_o       = own_addr;
          data_write_o = own_wdata;
          if (state_q == ST_GNT0) begin
            ack0_o   = 1'b1;
            rdata0_o = data_read_i;
          end else begin
            ack1_o   = 1'b1;
            rdata1_o = data_read_i;
          end
        end

        // Any owner transfer restarts the idle count; only idle locked cycles age it
        if (own_req) begin
          cnt_d = '0;
          if (own_lock) begin
            locked_d = 1'b1;
          end else begin
            locked_d = 1'b0;
            state_d  = ST_IDLE;
          end
        end else if (!locked_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d        = ST_IDLE;
          locked_d       = 1'b0;
          cnt_d          = '0;
          lock_timeout_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d  = ST_IDLE;
        locked_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
  end

  assign owner_o = owner_of(state_q);

endmodule

// File: tb/tb_regbus_arbiter.sv
// Directed, table-driven bench for regbus_arbiter: per-cycle input vectors with
// hand-computed outputs, plus lock, timeout and reset-mid-lock sequences.
module tb_regbus_arbiter;

  typedef struct {
    logic       rst_n;
    logic       req0, req1, lock0, lock1, we0, we1;
    logic [5:0] a0, a1;
    logic [7:0] d0, d1, drd;
    logic [36:0] exp;
  } vec_t;

  localparam logic [36:0] Z = '0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, lock0 = 0, lock1 = 0, we0 = 0, we1 = 0;
  logic [5:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0, data_read = '0;
  logic       ack0, ack1, read, write, lock_timeout;
  logic [7:0] rdata0, rdata1, data_write;
  logic [5:0] addr;
  logic [1:0] owner;
  logic [36:0] act;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  regbus_arbiter #(.LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_i(req0), .req1_i(req1), .lock0_i(lock0), .lock1_i(lock1),
    .we0_i(we0), .we1_i(we1), .addr0_i(addr0), .addr1_i(addr1),
    .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .read_o(read), .write_o(write), .addr_o(addr), .data_write_o(data_write),
    .data_read_i(data_read), .owner_o(owner), .lock_timeout_o(lock_timeout)
  );

  assign act = {ack0, ack1, rdata0, rdata1, read, write, addr, data_write, owner, lock_timeout};

  function automatic logic [36:0] E(input logic ak0, input logic ak1,
                                    input logic [7:0] r0, input logic [7:0] r1,
                                    input logic rd, input logic wr, input logic [5:0] ad,
                                    input logic [7:0] dw, input logic [1:0] own,
                                    input logic lt);
    return {ak0, ak1, r0, r1, rd, wr, ad, dw, own, lt};
  endfunction

  function automatic vec_t V(input logic rst, input logic rq0, input logic rq1,
                             input logic lk0, input logic lk1, input logic w0, input logic w1,
                             input logic [5:0] a0, input logic [5:0] a1,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] dr,
                             input logic [36:0] ex);
    vec_t v;
    v.rst_n = rst; v.req0 = rq0; v.req1 = rq1; v.lock0 = lk0; v.lock1 = lk1;
    v.we0 = w0; v.we1 = w1; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1; v.drd = dr;
    v.exp = ex;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst_n = v.rst_n; req0 = v.req0; req1 = v.req1; lock0 = v.lock0; lock1 = v.lock1;
    we0 = v.we0; we1 = v.we1; addr0 = v.a0; addr1 = v.a1;
    wdata0 = v.d0; wdata1 = v.d1; data_read = v.drd;
  endtask

  task automatic check(input vec_t v, input string name);
    nvec++;
    if (act !== v.exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", name, act, v.exp);
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    drive(v);
    #1;
    check(v, name);
  endtask

  vec_t tbl[17];
  vec_t g0, g1, both, v;

  initial begin
    // Basic write, read, then simultaneous unlocked requests after a reset
    tbl[0] = V(0, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h00, Z);
    tbl[1] = V(1, 1,0, 0,0, 1,0, 6'h00,6'h00, 8'h34,8'h00, 8'h00, Z);
    tbl[2] = V(1, 1,0, 0,0, 1,0, 6'h00,6'h00, 8'h34,8'h00, 8'h00,
               E(1,0, 8'h00,8'h00, 0,1, 6'h00, 8'h34, 2'b01, 0));
    tbl[3] = V(1, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h00, Z);
    tbl[4] = V(1, 1,0, 0,0, 0,0, 6'h08,6'h00, 8'h00,8'h00, 8'h5A, Z);
    tbl[5] = V(1, 1,0, 0,0, 0,0, 6'h08,6'h00, 8'h00,8'h00, 8'h5A,
               E(1,0, 8'h5A,8'h00, 1,0, 6'h08, 8'h00, 2'b01, 0));
    tbl[6] = V(1, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h5A, Z);
    tbl[7] = V(0, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h00, Z);
    both = V(1, 1,1, 0,0, 1,1, 6'h10,6'h07, 8'hA1,8'hB2, 8'h00, Z);
    g0 = both; g0.exp = E(1,0, 8'h00,8'h00, 0,1, 6'h10, 8'hA1, 2'b01, 0);
    g1 = both; g1.exp = E(0,1, 8'h00,8'h00, 0,1, 6'h07, 8'hB2, 2'b10, 0);
    tbl[8] = both; tbl[9] = g0; tbl[10] = both; tbl[11] = g1;
    tbl[12] = both; tbl[13] = g0; tbl[14] = both; tbl[15] = g1;
    tbl[16] = V(1, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h00, Z);

    for (int i = 0; i < 17; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Locked burst by requester 1 while requester 0 waits
    apply(V(0, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h00, Z), "lk_rst");
    apply(V(1, 0,1, 0,1, 0,1, 6'h00,6'h00, 8'h00,8'hE8, 8'h00, Z), "lk_idle");
    apply(V(1, 1,1, 0,1, 1,1, 6'h3F,6'h00, 8'h55,8'hE8, 8'h00,
            E(0,1, 8'h00,8'h00, 0,1, 6'h00, 8'hE8, 2'b10, 0)), "lk_wr0");
    apply(V(1, 1,1, 0,0, 1,1, 6'h3F,6'h01, 8'h55,8'h03, 8'h00,
            E(0,1, 8'h00,8'h00, 0,1, 6'h01, 8'h03, 2'b10, 0)), "lk_wr1");
    apply(V(1, 1,0, 0,0, 1,0, 6'h3F,6'h00, 8'h55,8'h00, 8'h00, Z), "lk_idle2");
    apply(V(1, 1,0, 0,0, 1,0, 6'h3F,6'h00, 8'h55,8'h00, 8'h00,
            E(1,0, 8'h00,8'h00, 0,1, 6'h3F, 8'h55, 2'b01, 0)), "lk_req0");
    apply(V(1, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h00, Z), "lk_done");

    // Lock timeout: owner drops req for LOCK_TIMEOUT cycles
    apply(V(0, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h00, Z), "to_rst");
    apply(V(1, 0,1, 0,1, 0,1, 6'h00,6'h02, 8'h00,8'h11, 8'h00, Z), "to_idle");
    apply(V(1, 0,1, 0,1, 0,1, 6'h00,6'h02, 8'h00,8'h11, 8'h00,
            E(0,1, 8'h00,8'h00, 0,1, 6'h02, 8'h11, 2'b10, 0)), "to_lock");
    for (int k = 0; k < 16; k++)
      apply(V(1, 1,0, 0,0, 0,0, 6'h05,6'h00, 8'h00,8'h00, 8'h77,
              E(0,0, 8'h00,8'h00, 0,0, 6'h00, 8'h00, 2'b10, (k == 15))),
            $sformatf("to_wait[%0d]", k));
    apply(V(1, 1,0, 0,0, 0,0, 6'h05,6'h00, 8'h00,8'h00, 8'h77, Z), "to_released");
    apply(V(1, 1,0, 0,0, 0,0, 6'h05,6'h00, 8'h00,8'h00, 8'h77,
            E(1,0, 8'h77,8'h00, 1,0, 6'h05, 8'h00, 2'b01, 0)), "to_req0");
    apply(V(1, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h00, Z), "to_done");

    // Reset asserted in the middle of a locked sequence
    apply(V(0, 0,0, 0,0, 0,0, 6'h00,6'h00, 8'h00,8'h00, 8'h00, Z), "mr_rst");
    apply(V(1, 0,1, 0,1, 0,1, 6'h00,6'h04, 8'h00,8'h22, 8'h00, Z), "mr_idle");
    apply(V(1, 0,1, 0,1, 0,1, 6'h00,6'h04, 8'h00,8'h22, 8'h00,
            E(0,1, 8'h00,8'h00, 0,1, 6'h04, 8'h22, 2'b10, 0)), "mr_wr0");
    apply(V(1, 1,1, 0,1, 0,1, 6'h0A,6'h05, 8'h00,8'h23, 8'h00,
            E(0,1, 8'h00,8'h00, 0,1, 6'h05, 8'h23, 2'b10, 0)), "mr_wr1");
    v = V(0, 1,1, 0,1, 0,1, 6'h0A,6'h05, 8'h00,8'h23, 8'h00, Z);
    drive(v);
    #1;
    check(v, "mr_async");
    apply(V(1, 1,1, 0,0, 0,1, 6'h0A,6'h06, 8'h00,8'h24, 8'h66, Z), "mr_post_idle");
    apply(V(1, 1,1, 0,0, 0,1, 6'h0A,6'h06, 8'h00,8'h24, 8'h66,
            E(1,0, 8'h66,8'h00, 1,0, 6'h0A, 8'h00, 2'b01, 0)), "mr_first_grant");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/regbus_arbiter.md
# regbus_arbiter

Two-requester arbiter sharing the single decoder-facing port of the PWM register block (read/write/addr/data_write/data_read). Requester 0 is the host decoder; requester 1 is an on-chip sequencer that updates compare/period values autonomously. Round-robin grant with a lock mechanism, so a requester can perform multi-byte updates (e.g. period low then high byte) without interleaving. Lock ownership is bounded by a timeout.

## Interface
- LOCK_TIMEOUT, default 16: idle cycles a locked owner may hold the bus without requesting before forced release; legal range 2..255.
- clk  in  1  peripheral clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req0 / req1  in  1  transfer request; held stable with we/addr/wdata until ack.
- lock0 / lock1  in  1  sampled on the acked transfer; 1 = keep ownership after this transfer.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  6  register address.
- wdata0 / wdata1  in  8  write data.
- ack0 / ack1  out  1  transfer completes this cycle.
- rdata0 / rdata1  out  8  read data, valid while the matching ack is high; 0 otherwise.
- read  out  1  to register block.
- write  out  1  to register block.
- addr  out  6  to register block.
- data_write  out  8  to register block.
- data_read  in  8  from register block; combinational on read/addr.
- owner  out  2  00 none, 01 requester 0, 10 requester 1.
- lock_timeout  out  1  one-cycle pulse on forced lock release.

## Operation
- FSM states: IDLE, GNT0, GNT1. Registered state: a locked flag, a round-robin pointer rr (the requester favoured on a tie), and a timeout counter of 8 bits.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the requester given by rr.
  - On any grant, rr becomes the other requester.
  - Bus outputs are all 0 in IDLE.
- GNTi bus drive:
  - read = req_i & ~we_i.
  - write = req_i & we_i.
  - addr and data_write come from requester i while req_i is high; otherwise 0.
  - ack_i = req_i.
  - rdata_i = data_read when ack_i is high.
  - The non-owner sees ack = 0 and rdata = 0.
- GNTi transitions:
  - ack with lock_i = 0: clear locked, go to IDLE.
  - ack with lock_i = 1: set locked, stay in GNTi, clear the counter.
  - req_i low and locked = 0: go to IDLE.
  - req_i low and locked = 1: increment the counter.
  - Counter reaches LOCK_TIMEOUT-1 with req_i still low: go to IDLE, clear locked, pulse lock_timeout.
- Addresses and data pass through unmodified, including the write-only address 0x07. The arbiter does not decode the register map.
- owner reflects the state register directly.

## Timing
- Reset values:
  - State IDLE, locked 0, rr = requester 0, counter 0.
  - All outputs 0: ack0/1, rdata0/1, read, write, addr, data_write, owner, lock_timeout.
- Reset asserted mid-transfer or mid-lock drops ownership immediately (asynchronously). The first grant after reset favours requester 0.
- Latency:
  - A request seen in IDLE at edge n is granted at edge n+1.
  - The transfer and its ack occur in cycle n+1, combinationally from the state.
  - The earliest next grant is at edge n+2.
  - Unlocked throughput is one transfer per 2 cycles per requester.
- Locked throughput is one transfer per cycle while the owner keeps req high.
- A non-owner request is held pending indefinitely and is not dropped. The requester must keep req asserted.
- Requester 0 and requester 1 both request continuously, unlocked: grants alternate 0,1,0,1.
- Timeout accounting: the counter counts only cycles with the owner's req low. Any owner request resets it to 0.
- Lock released by an ack with lock = 0: the final transfer completes normally.

## Structure
- Shared package holds:
  - State encoding (IDLE, GNT0, GNT1).
  - Owner encoding constants (2'b00/01/10).
  - Register-bus width constants: address 6, data 8.
- No sub-module. Bus muxing, FSM and counter are a single module.

## Test plan
- Reset, then req0 write addr 0x00 data 0x34 → owner = 01 one cycle later; write = 1, addr = 0x00, data_write = 0x34, ack0 = 1 for exactly one cycle; owner returns to 00.
- req0 and req1 rise together, both unlocked, held for 8 cycles → acks alternate ack0, ack1, ack0, ack1 at 2-cycle spacing; no cycle has both acks high.
- Requester 1 locked write 0x00 = 0xE8 then unlocked write 0x01 = 0x03 while req0 is held → writes occur on consecutive cycles; requester 0 is acked only after the 0x01 write.
- Requester 1 acquires a lock, then drops req, with LOCK_TIMEOUT = 16 → after 16 idle cycles lock_timeout pulses once and owner = 00; pending req0 is granted on the next edge.
- Requester 0 reads addr 0x08 with data_read driven to 0x5A → read = 1, we = 0, rdata0 = 0x5A with ack0; rdata1 stays 0.
- rst_n asserted low while requester 1 holds a lock mid-sequence → owner, ack, read and write go to 0 immediately; after release, simultaneous requests grant requester 0 first.
